// File: rtl/trade_risk_sequencer.sv
// trade_risk_sequencer: per-client risk check of trades against a cached max/accumulated pair,
// one order in flight, with cache timeout and saturating accept/reject counters.
module trade_risk_sequencer #(
    parameter int CLIENT_W = 10,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ord_valid,
    output logic                ord_ready,
    input  logic [CLIENT_W-1:0] ord_client,
    input  logic [15:0]         ord_amount,
    input  logic                ord_set_max,
    output logic                req_valid,
    output logic                req_rw,
    output logic [13:0]         req_index,
    output logic [31:0]         req_data,
    input  logic                res_ready,
    input  logic [31:0]         res_data,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic                dec_accept,
    output logic                dec_timeout,
    output logic [CLIENT_W-1:0] dec_client,
    output logic [15:0]         acc_count,
    output logic [15:0]         rej_count
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, CHECK, WR_REQ, DECIDE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   amount;
    logic [31:0]   res_q;
    logic [16:0]   sum;
    logic          ok;

    // 17-bit sum so a wrap past 16 bits is rejected rather than compared
    assign sum = {1'b0, res_q[15:0]} + {1'b0, amount};
    assign ok  = (res_q[31:16] != 16'h0000) && !sum[16] && (sum[15:0] <= res_q[31:16]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            amount      <= '0;
            res_q       <= '0;
            ord_ready   <= 1'b0;
            req_valid   <= 1'b0;
            req_rw      <= 1'b0;
            req_index   <= '0;
            req_data    <= '0;
            dec_valid   <= 1'b0;
            dec_accept  <= 1'b0;
            dec_timeout <= 1'b0;
            dec_client  <= '0;
            acc_count   <= '0;
            rej_count   <= '0;
        end else begin
            case (state)
                IDLE: if (ord_ready && ord_valid) begin
                    ord_ready   <= 1'b0;
                    amount      <= ord_amount;
                    dec_client  <= ord_client;
                    req_index   <= 14'({ord_client, 4'b0000});
                    cnt         <= '0;
                    dec_accept  <= 1'b0;
                    dec_timeout <= 1'b0;
                    if (!ord_set_max) begin
                        state     <= RD_REQ;
                        req_valid <= 1'b1;
                        req_rw    <= 1'b0;
                        req_data  <= '0;
                    end else if (ord_amount > 16'd1) begin
                        state     <= WR_REQ;
                        req_valid <= 1'b1;
                        req_rw    <= 1'b1;
                        req_data  <= {ord_amount, 16'h0000};
                    end else begin
                        state     <= DECIDE;
                        dec_valid <= 1'b1;
                    end
                end else begin
                    ord_ready <= 1'b1;
                end
                RD_REQ: if (res_ready) begin
                    req_valid <= 1'b0;
                    res_q     <= res_data;
                    state     <= CHECK;
                end else if (cnt == LAST) begin
                    req_valid   <= 1'b0;
                    dec_valid   <= 1'b1;
                    dec_timeout <= 1'b1;
                    state       <= DECIDE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                CHECK: if (ok) begin
                    state     <= WR_REQ;
                    req_valid <= 1'b1;
                    req_rw    <= 1'b1;
                    req_data  <= {16'h0000, amount};
                    cnt       <= '0;
                end else begin
                    state     <= DECIDE;
                    dec_valid <= 1'b1;
                end
                WR_REQ: if (res_ready) begin
                    req_valid  <= 1'b0;
                    req_rw     <= 1'b0;
                    dec_valid  <= 1'b1;
                    dec_accept <= 1'b1;
                    state      <= DECIDE;
                end else if (cnt == LAST) begin
                    req_valid   <= 1'b0;
                    req_rw      <= 1'b0;
                    dec_valid   <= 1'b1;
                    dec_timeout <= 1'b1;
                    state       <= DECIDE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DECIDE: if (dec_ready) begin
                    dec_valid <= 1'b0;
                    ord_ready <= 1'b1;
                    state     <= IDLE;
                    if (dec_accept && acc_count != 16'hFFFF) acc_count <= acc_count + 1'b1;
                    if (!dec_accept && rej_count != 16'hFFFF) rej_count <= rej_count + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trade_risk_sequencer.sv
// tb_trade_risk_sequencer: directed scenarios with hand-computed expectations.
module tb_trade_risk_sequencer;
    logic        clk = 0;
    logic        rst = 1;
    logic        ord_valid = 0;
    logic        ord_ready;
    logic [9:0]  ord_client = 0;
    logic [15:0] ord_amount = 0;
    logic        ord_set_max = 0;
    logic        req_valid, req_rw;
    logic [13:0] req_index;
    logic [31:0] req_data;
    logic        res_ready = 0;
    logic [31:0] res_data = 0;
    logic        dec_valid;
    logic        dec_ready = 1;
    logic        dec_accept, dec_timeout;
    logic [9:0]  dec_client;
    logic [15:0] acc_count, rej_count;

    int total = 0;
    int bad = 0;
    int rd_n = 0, wr_n = 0, req_n = 0;
    logic [13:0] rd_idx = 0, wr_idx = 0;
    logic [31:0] wr_data = 0;

    trade_risk_sequencer dut (
        .clk(clk), .rst(rst),
        .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_client(ord_client),
        .ord_amount(ord_amount), .ord_set_max(ord_set_max),
        .req_valid(req_valid), .req_rw(req_rw), .req_index(req_index), .req_data(req_data),
        .res_ready(res_ready), .res_data(res_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_accept(dec_accept),
        .dec_timeout(dec_timeout), .dec_client(dec_client),
        .acc_count(acc_count), .rej_count(rej_count)
    );

    always #5 clk = ~clk;

    // cache-side observer: completed reads/writes and any request activity
    always @(posedge clk) begin
        if (req_valid) req_n <= req_n + 1;
        if (req_valid && res_ready && !req_rw) begin
            rd_n   <= rd_n + 1;
            rd_idx <= req_index;
        end
        if (req_valid && res_ready && req_rw) begin
            wr_n    <= wr_n + 1;
            wr_idx  <= req_index;
            wr_data <= req_data;
        end
    end

    task automatic send(input logic [9:0] c, input logic [15:0] a, input logic sm);
        int n = 0;
        ord_client = c; ord_amount = a; ord_set_max = sm; ord_valid = 1;
        while (!ord_ready && n < 20) begin @(negedge clk); n++; end
        total++;
        if (ord_ready !== 1'b1) begin bad++; $display("FAIL ord_handshake got=%b exp=1", ord_ready); end
        @(negedge clk);
        ord_valid = 0;
    endtask

    task automatic wait_dec(output int lat);
        lat = 1;
        while (!dec_valid && lat < 200) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (ord_ready !== 1'b0) begin bad++; $display("FAIL rst_ord_ready got=%b exp=0", ord_ready); end
        total++; if ({req_valid, req_rw, req_index, req_data} !== 47'd0) begin bad++; $display("FAIL rst_req got=%b/%b/%h/%h exp=0", req_valid, req_rw, req_index, req_data); end
        total++; if ({dec_valid, dec_accept, dec_timeout, dec_client} !== 13'd0) begin bad++; $display("FAIL rst_dec got=%b/%b/%b/%h exp=0", dec_valid, dec_accept, dec_timeout, dec_client); end
        total++; if ({acc_count, rej_count} !== 32'd0) begin bad++; $display("FAIL rst_counts got=%h/%h exp=0", acc_count, rej_count); end
        rst = 0;
        @(negedge clk);
        total++; if (ord_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", ord_ready); end
    endtask

    task automatic test_trade_accept;
        int lat, r0, w0;
        r0 = rd_n; w0 = wr_n;
        res_ready = 1; res_data = 32'h0100_0020;
        send(10'd3, 16'h0010, 1'b0);
        wait_dec(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL accept_latency got=%0d exp=4", lat); end
        total++; if (rd_n - r0 !== 1 || rd_idx !== 14'h030) begin bad++; $display("FAIL accept_read got=%0d@%h exp=1@030", rd_n - r0, rd_idx); end
        total++; if (wr_n - w0 !== 1 || wr_idx !== 14'h030 || wr_data !== 32'h0000_0010) begin bad++; $display("FAIL accept_write got=%0d@%h=%h exp=1@030=00000010", wr_n - w0, wr_idx, wr_data); end
        total++; if ({dec_valid, dec_accept, dec_timeout, dec_client} !== {3'b110, 10'd3}) begin bad++; $display("FAIL accept_dec got=%b%b%b/%h exp=110/003", dec_valid, dec_accept, dec_timeout, dec_client); end
        @(negedge clk);
        total++; if (acc_count !== 16'd1 || rej_count !== 16'd0) begin bad++; $display("FAIL accept_counts got=%0d/%0d exp=1/0", acc_count, rej_count); end
    endtask

    task automatic test_trade_reject(input string name, input logic [15:0] a, input logic [31:0] rd, input logic [15:0] exp_rej);
        int lat, w0;
        w0 = wr_n;
        res_ready = 1; res_data = rd;
        send(10'd4, a, 1'b0);
        wait_dec(lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL %s_latency got=%0d exp=3", name, lat); end
        total++; if (wr_n !== w0) begin bad++; $display("FAIL %s_nowrite got=%0d exp=0", name, wr_n - w0); end
        total++; if ({dec_valid, dec_accept, dec_timeout} !== 3'b100) begin bad++; $display("FAIL %s_dec got=%b%b%b exp=100", name, dec_valid, dec_accept, dec_timeout); end
        @(negedge clk);
        total++; if (rej_count !== exp_rej || acc_count !== 16'd1) begin bad++; $display("FAIL %s_counts got=%0d/%0d exp=1/%0d", name, acc_count, rej_count, exp_rej); end
    endtask

    task automatic test_set_max;
        int lat, r0, w0, q0;
        r0 = rd_n; w0 = wr_n;
        res_ready = 1;
        send(10'd5, 16'h0200, 1'b1);
        wait_dec(lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL setmax_latency got=%0d exp=2", lat); end
        total++; if (rd_n !== r0 || wr_n - w0 !== 1 || wr_idx !== 14'h050 || wr_data !== 32'h0200_0000) begin bad++; $display("FAIL setmax_write got=rd%0d wr%0d@%h=%h exp=rd0 wr1@050=02000000", rd_n - r0, wr_n - w0, wr_idx, wr_data); end
        total++; if ({dec_valid, dec_accept, dec_client} !== {2'b11, 10'd5}) begin bad++; $display("FAIL setmax_dec got=%b%b/%h exp=11/005", dec_valid, dec_accept, dec_client); end
        @(negedge clk);
        total++; if (acc_count !== 16'd2) begin bad++; $display("FAIL setmax_acc got=%0d exp=2", acc_count); end
        q0 = req_n;
        send(10'd5, 16'h0001, 1'b1);
        wait_dec(lat);
        total++; if (lat !== 1 || req_n !== q0) begin bad++; $display("FAIL setmax1_noreq got=lat%0d req%0d exp=lat1 req0", lat, req_n - q0); end
        total++; if ({dec_valid, dec_accept, dec_timeout} !== 3'b100) begin bad++; $display("FAIL setmax1_dec got=%b%b%b exp=100", dec_valid, dec_accept, dec_timeout); end
        @(negedge clk);
        total++; if (rej_count !== 16'd4) begin bad++; $display("FAIL setmax1_rej got=%0d exp=4", rej_count); end
    endtask

    task automatic test_timeout;
        int lat, w0;
        logic [9:0] cl;
        w0 = wr_n;
        res_ready = 0; dec_ready = 0;
        send(10'd7, 16'h0005, 1'b0);
        wait_dec(lat);
        total++; if (lat !== 65) begin bad++; $display("FAIL timeout_latency got=%0d exp=65", lat); end
        total++; if ({dec_valid, dec_accept, dec_timeout, dec_client} !== {3'b101, 10'd7} || wr_n !== w0) begin bad++; $display("FAIL timeout_dec got=%b%b%b/%h wr%0d exp=101/007 wr0", dec_valid, dec_accept, dec_timeout, dec_client, wr_n - w0); end
        cl = dec_client;
        ord_client = 10'd9; ord_amount = 16'h0001; ord_set_max = 0; ord_valid = 1;
        res_ready = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({dec_valid, dec_accept, dec_timeout, dec_client, ord_ready, req_valid} !== {3'b101, cl, 2'b00}) begin
                bad++; $display("FAIL hold_stable got=%b%b%b/%h rdy%b req%b exp=101/%h rdy0 req0", dec_valid, dec_accept, dec_timeout, dec_client, ord_ready, req_valid, cl);
            end
        end
        ord_valid = 0; dec_ready = 1;
        @(negedge clk);
        total++; if (dec_valid !== 1'b0 || rej_count !== 16'd5 || acc_count !== 16'd2) begin bad++; $display("FAIL timeout_counts got=v%b %0d/%0d exp=v0 2/5", dec_valid, acc_count, rej_count); end
    endtask

    task automatic test_reset_mid_write;
        logic seen = 0;
        res_ready = 0;
        send(10'd5, 16'h0300, 1'b1);
        total++; if ({req_valid, req_rw, req_index, req_data} !== {2'b11, 14'h050, 32'h0300_0000}) begin bad++; $display("FAIL midwr_req got=%b%b/%h/%h exp=11/050/03000000", req_valid, req_rw, req_index, req_data); end
        rst = 1;
        @(negedge clk);
        total++; if ({req_valid, dec_valid, ord_ready} !== 3'b000 || {acc_count, rej_count} !== 32'd0) begin bad++; $display("FAIL midwr_rst got=req%b dec%b rdy%b %0d/%0d exp=0 0 0 0/0", req_valid, dec_valid, ord_ready, acc_count, rej_count); end
        rst = 0; res_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dec_valid || req_valid) seen = 1;
        end
        total++; if (seen !== 1'b0 || ord_ready !== 1'b1) begin bad++; $display("FAIL midwr_after got=activity%b rdy%b exp=activity0 rdy1", seen, ord_ready); end
    endtask

    task automatic test_back_to_back;
        int lat;
        res_ready = 1; res_data = 32'h0100_0020; dec_ready = 1;
        for (int k = 0; k < 2; k++) begin
            send(10'd3, 16'h0010, 1'b0);
            wait_dec(lat);
            total++; if (dec_accept !== 1'b1 || lat !== 4) begin bad++; $display("FAIL b2b_dec%0d got=acc%b lat%0d exp=acc1 lat4", k, dec_accept, lat); end
            @(negedge clk);
        end
        total++; if (acc_count !== 16'd2 || rej_count !== 16'd0) begin bad++; $display("FAIL b2b_counts got=%0d/%0d exp=2/0", acc_count, rej_count); end
    endtask

    initial begin
        test_reset();
        test_trade_accept();
        test_trade_reject("over_max", 16'h00F0, 32'h0100_0020, 16'd1);
        test_trade_reject("overflow", 16'hFFFF, 32'hFFFF_0002, 16'd2);
        test_trade_reject("max_zero", 16'h0001, 32'h0000_0000, 16'd3);
        test_set_max();
        test_timeout();
        test_reset_mid_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
